// File: rtl/io_bcd_display.sv
// io_bcd_display: double-dabble binary-to-BCD driver for six active-low 7-segment displays (two digits per I/O port).
// Ports: clock/reset (sync, active-high); out_port0..2 = data-memory I/O output ports;
//        hex0..hex5 = gfedcba active-low digits (units/tens per port); ovf[n] = channel n >= 100;
//        neg2 = channel 2 negative; update = one-cycle pulse after a full 3-channel refresh.
module io_bcd_display #(
  parameter int WIDTH   = 7,
  parameter int SIGNED2 = 1,
  parameter int BLANK   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [2:0]  ovf,
  output logic        neg2,
  output logic        update
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
  state_t state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [WIDTH-1:0] bin, snap, mag;
  logic [11:0] bcd, bcd_adj;
  logic sign, neg_in;
  logic [6:0] seg_u, seg_t;
  logic unused_bits;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction
  assign snap = ch == 2'd0 ? out_port0[WIDTH-1:0] : ch == 2'd1 ? out_port1[WIDTH-1:0] : out_port2[WIDTH-1:0];
  assign neg_in = SIGNED2 != 0 && ch == 2'd2 && snap[WIDTH-1];
  // the most negative value negates to itself, which read unsigned is the right magnitude
  assign mag = neg_in ? ~snap + 1'b1 : snap;
  assign bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
  assign seg_u = seg(bcd[3:0]);
  assign seg_t = (BLANK != 0 && bcd[7:4] == 4'd0) ? 7'b1111111 : seg(bcd[7:4]);
  assign unused_bits = ^{out_port0[31:WIDTH], out_port1[31:WIDTH], out_port2[31:WIDTH], bcd_adj[11]};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ch <= 2'd0;
      cnt <= 4'd0;
      bin <= '0;
      bcd <= 12'd0;
      sign <= 1'b0;
      {hex0, hex1, hex2, hex3, hex4, hex5} <= {6{7'b1111111}};
      ovf <= 3'b000;
      neg2 <= 1'b0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          bin <= mag;
          sign <= neg_in;
          bcd <= 12'd0;
          cnt <= 4'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd <= {bcd_adj[10:0], bin[WIDTH-1]};
          bin <= bin << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(WIDTH-1)) state <= STORE;
        end
        STORE: begin
          ovf[ch] <= |bcd[11:8];
          if (ch == 2'd0) {hex1, hex0} <= {seg_t, seg_u};
          if (ch == 2'd1) {hex3, hex2} <= {seg_t, seg_u};
          if (ch == 2'd2) begin
            {hex5, hex4} <= {seg_t, seg_u};
            neg2 <= sign;
            update <= 1'b1;
          end
          ch <= ch == 2'd2 ? 2'd0 : ch + 2'd1;
          state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
